regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V datapath. Provides NUM_RD combinational read ports and NUM_WR clocked write ports, with optional same-cycle write-to-read bypass. It also holds a per-register pending (scoreboard) bit so issue logic can detect RAW hazards. It replaces the single-write, dual-read register file in the decode stage and serves dual-writeback configurations (ALU plus load return).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads see stored contents only

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses slice i
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  pending bit of each read address
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*ADDR_W  packed write addresses
wr_data  in  NUM_WR*DATA_W  packed write data
rsv_en  in  1  reserve a destination (set its pending bit)
rsv_addr  in  ADDR_W  destination being reserved
wr_conflict  out  1  registered one-cycle pulse: two enabled write ports targeted the same nonzero address

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all pending bits = 0, wr_conflict = 0. It takes effect immediately mid-cycle, so rd_data reads 0 while in reset. Release is synchronised externally.
- Register 0 is hardwired to zero:
  - Writes to it are ignored.
  - rd_data for address 0 is always 0.
  - rd_busy for address 0 is always 0.
  - rsv_en with rsv_addr = 0 has no effect.
- Writes: on posedge clk, for each port p with wr_en[p] and wr_addr[p] != 0, RF[wr_addr[p]] <= wr_data[p].
- Same-address writes: if two ports target the same address, the higher-index port wins. wr_conflict is asserted for exactly the following cycle.
- Reads are combinational with zero latency.
  - BYPASS = 1: if any enabled write port matches rd_addr[i] (nonzero), rd_data[i] = that port's wr_data (highest index wins). Otherwise rd_data[i] = RF[rd_addr[i]].
  - BYPASS = 0: rd_data[i] is the stored value; new data is visible the cycle after the write edge.
- Pending bits: busy[a] is set at posedge when rsv_en and rsv_addr = a. It is cleared at posedge when any enabled write port writes a.
- Reserve and write to the same address in the same cycle: the reserve wins and busy stays 1 (a new producer was issued).
- rd_busy[i] = busy[rd_addr[i]].
  - With BYPASS = 1, rd_busy[i] is forced to 0 when a same-cycle enabled write matches rd_addr[i].
  - Exception: a simultaneous reserve to that address keeps rd_busy[i] = 1.
- A write to a non-pending register is legal; it updates data and leaves busy at 0.
- No wrap-around: every address is in range by construction (depth = 2**ADDR_W).

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W
  - REG_ZERO constant (0)
  - a localparam function computing the packed-slice offset
- One sub-module: regfile_scoreboard (2**ADDR_W pending bits; set/clear logic and reserve-priority rule; busy lookup per read port). Data array, bypass muxing and conflict detection stay in regfile_mp.

Test Plan:
1. Reset with RF preloaded by writes -> after rst_n low, all rd_data = 0 and rd_busy = 0. Assert rst_n low mid-cycle -> rd_data drops to 0 without a clock edge.
2. Write x5 = 0xDEADBEEF on port 0 while reading rd_addr[0] = 5 -> BYPASS = 1: same-cycle rd_data = 0xDEADBEEF. BYPASS = 0: old value, then 0xDEADBEEF the next cycle.
3. Write port 0 (x7 = 0x11) and port 1 (x7 = 0x22) in one cycle -> RF[7] = 0x22 and wr_conflict = 1 for exactly one cycle. Write x0 = 0xFFFF -> x0 still reads 0.
4. rsv_en on x9; next cycle read x9 -> rd_busy = 1. Write x9 = 0x55 -> bypass read gives 0x55 with rd_busy = 0; the following cycle busy = 0.
5. Same cycle: rsv_en x12 and port 1 write x12 = 0xA5 -> RF[12] = 0xA5, busy[12] stays 1. A later write clears it.
6. NUM_RD = 4, NUM_WR = 1: four simultaneous reads of x1, x2, x0, x1 -> correct independent data, and x0 read = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the
// multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // bit offset of slice idx in a packed bus of w-bit lanes
  function automatic int slice_off(int idx, int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/reserve bus of the register file.
// master = issue/writeback side, slave = regfile_mp.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr,
    input  rd_data, rd_busy, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr,
    output rd_data, rd_busy, wr_conflict
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits.
// Ports: clk, rst_n, reserve, write enables/addrs,
// read addrs in, per-read-port busy out.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO =
    ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];

  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      wa[p] = wr_addr[slice_off(p, ADDR_W) +: ADDR_W];
    for (int i = 0; i < NUM_RD; i++)
      ra[i] = rd_addr[slice_off(i, ADDR_W) +: ADDR_W];
  end

  // reserve is applied last so a new producer wins
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_en[p]) busy_nxt[wa[p]] = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  logic hit;
  logic b;

  always_comb begin
    rd_busy = '0;
    hit     = 1'b0;
    b       = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (wr_en[p] && wa[p] == ra[i]) hit = 1'b1;
      b = busy[ra[i]];
      // a completing write frees the reader unless
      // it is re-reserved in the same cycle
      if (BYPASS != 0 && hit)
        b = rsv_en && (rsv_addr == ra[i]);
      if (ra[i] == ZERO || !rst_n) b = 1'b0;
      rd_busy[i] = b;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / NUM_WR-write register file
// with optional write bypass, pending bits and conflict flag.
// Ports: clk, rst_n, bus (regfile_if.slave).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input logic      clk,
  input logic      rst_n,
  regfile_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO =
    ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic              conf;

  always_comb begin
    for (int p = 0; p < NUM_WR; p++) begin
      wa[p] = bus.wr_addr[slice_off(p, ADDR_W) +: ADDR_W];
      wd[p] = bus.wr_data[slice_off(p, DATA_W) +: DATA_W];
    end
    for (int i = 0; i < NUM_RD; i++)
      ra[i] = bus.rd_addr[slice_off(i, ADDR_W) +: ADDR_W];
  end

  // ascending port order: higher index wins a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) rf[a] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (bus.wr_en[p] && wa[p] != ZERO)
          rf[wa[p]] <= wd[p];
    end
  end

  logic [DATA_W-1:0] d;

  always_comb begin
    bus.rd_data = '0;
    d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      d = rf[ra[i]];
      if (BYPASS != 0)
        for (int p = 0; p < NUM_WR; p++)
          if (bus.wr_en[p] && wa[p] == ra[i] &&
              ra[i] != ZERO)
            d = wd[p];
      // bypass must not leak write data during reset
      if (!rst_n) d = '0;
      bus.rd_data[slice_off(i, DATA_W) +: DATA_W] = d;
    end
  end

  always_comb begin
    conf = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (bus.wr_en[p] && bus.wr_en[q] &&
            wa[p] == wa[q] && wa[p] != ZERO)
          conf = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_conflict <= 1'b0;
    else        bus.wr_conflict <= conf;
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (bus.rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp in
// bypass, no-bypass and 4-read/1-write builds.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_if #(.NUM_RD(2), .NUM_WR(2)) ifa ();
  regfile_if #(.NUM_RD(2), .NUM_WR(2)) ifb ();
  regfile_if #(.NUM_RD(4), .NUM_WR(1)) ifc ();

  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  regfile_mp #(.NUM_RD(4), .NUM_WR(1), .BYPASS(1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.wr_en = '0; ifa.rsv_en = 1'b0;
    ifb.wr_en = '0; ifb.rsv_en = 1'b0;
    ifc.wr_en = '0; ifc.rsv_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    ifa.rd_addr = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifb.rd_addr = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifc.rd_addr = '0; ifc.wr_addr = '0; ifc.wr_data = '0;
    ifa.rsv_addr = '0; ifb.rsv_addr = '0;
    ifc.rsv_addr = '0;
    tick(); tick();
    check("rst_data", {32'h0, ifa.rd_data[31:0]}, 64'h0);
    check("rst_busy", {62'h0, ifa.rd_busy}, 64'h0);
    check("rst_conf", {63'h0, ifa.wr_conflict}, 64'h0);
    rst_n = 1'b1;

    // 1: preload, reserve, then async reset mid-cycle
    ifa.wr_en = 2'b11;
    ifa.wr_addr = {5'd4, 5'd3};
    ifa.wr_data = {32'h44, 32'h33};
    tick();
    idle();
    ifa.rd_addr = {5'd4, 5'd3};
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd3;
    tick();
    idle();
    #1;
    check("pre_r0", {32'h0, ifa.rd_data[31:0]}, 64'h33);
    check("pre_r1", {32'h0, ifa.rd_data[63:32]}, 64'h44);
    check("pre_busy", {62'h0, ifa.rd_busy}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_r0", {32'h0, ifa.rd_data[31:0]}, 64'h0);
    check("async_r1", {32'h0, ifa.rd_data[63:32]}, 64'h0);
    check("async_busy", {62'h0, ifa.rd_busy}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_r0", {32'h0, ifa.rd_data[31:0]}, 64'h0);

    // 2: write x5 with a same-cycle read
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd5};
    ifa.wr_data = {32'h0, 32'hDEADBEEF};
    ifa.rd_addr = {5'd0, 5'd5};
    ifb.wr_en = 2'b01; ifb.wr_addr = {5'd0, 5'd5};
    ifb.wr_data = {32'h0, 32'hDEADBEEF};
    ifb.rd_addr = {5'd0, 5'd5};
    #1;
    check("byp_a", {32'h0, ifa.rd_data[31:0]}, 64'hDEADBEEF);
    check("nobyp_b", {32'h0, ifb.rd_data[31:0]}, 64'h0);
    tick();
    idle();
    #1;
    check("stored_a", {32'h0, ifa.rd_data[31:0]}, 64'hDEADBEEF);
    check("stored_b", {32'h0, ifb.rd_data[31:0]}, 64'hDEADBEEF);

    // 3: both ports hit x7, then write to x0
    ifa.wr_en = 2'b11; ifa.wr_addr = {5'd7, 5'd7};
    ifa.wr_data = {32'h22, 32'h11};
    ifa.rd_addr = {5'd0, 5'd7};
    #1;
    check("byp_hi_wins", {32'h0, ifa.rd_data[31:0]}, 64'h22);
    check("conf_early", {63'h0, ifa.wr_conflict}, 64'h0);
    tick();
    idle();
    #1;
    check("x7_stored", {32'h0, ifa.rd_data[31:0]}, 64'h22);
    check("conf_pulse", {63'h0, ifa.wr_conflict}, 64'h1);
    tick();
    check("conf_clear", {63'h0, ifa.wr_conflict}, 64'h0);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd0};
    ifa.wr_data = {32'h0, 32'hFFFF};
    ifa.rd_addr = {5'd0, 5'd0};
    #1;
    check("x0_byp", {32'h0, ifa.rd_data[31:0]}, 64'h0);
    tick();
    idle();
    #1;
    check("x0_read", {32'h0, ifa.rd_data[31:0]}, 64'h0);

    // 4: reserve x9, then its producer writes back
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9;
    ifb.rsv_en = 1'b1; ifb.rsv_addr = 5'd9;
    tick();
    idle();
    ifa.rd_addr = {5'd0, 5'd9};
    ifb.rd_addr = {5'd0, 5'd9};
    #1;
    check("x9_busy", {62'h0, ifa.rd_busy}, 64'h1);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd9};
    ifa.wr_data = {32'h0, 32'h55};
    ifb.wr_en = 2'b01; ifb.wr_addr = {5'd0, 5'd9};
    ifb.wr_data = {32'h0, 32'h55};
    #1;
    check("x9_byp", {32'h0, ifa.rd_data[31:0]}, 64'h55);
    check("x9_byp_free", {62'h0, ifa.rd_busy}, 64'h0);
    check("x9_nobyp_busy", {62'h0, ifb.rd_busy}, 64'h1);
    tick();
    idle();
    #1;
    check("x9_free", {62'h0, ifa.rd_busy}, 64'h0);
    check("x9_free_b", {62'h0, ifb.rd_busy}, 64'h0);
    check("x9_data", {32'h0, ifa.rd_data[31:0]}, 64'h55);

    // 5: reserve and write x12 in the same cycle
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd12;
    ifa.wr_en = 2'b10; ifa.wr_addr = {5'd12, 5'd0};
    ifa.wr_data = {32'hA5, 32'h0};
    ifa.rd_addr = {5'd0, 5'd12};
    #1;
    check("x12_same_busy", {62'h0, ifa.rd_busy}, 64'h1);
    tick();
    idle();
    #1;
    check("x12_data", {32'h0, ifa.rd_data[31:0]}, 64'hA5);
    check("x12_busy", {62'h0, ifa.rd_busy}, 64'h1);
    ifa.wr_en = 2'b01; ifa.wr_addr = {5'd0, 5'd12};
    ifa.wr_data = {32'h0, 32'h5A};
    tick();
    idle();
    #1;
    check("x12_clear", {62'h0, ifa.rd_busy}, 64'h0);
    check("x12_new", {32'h0, ifa.rd_data[31:0]}, 64'h5A);

    // 6: four read ports, one write port
    ifc.wr_en = 1'b1; ifc.wr_addr = 5'd1;
    ifc.wr_data = 32'h1111;
    tick();
    ifc.wr_addr = 5'd2; ifc.wr_data = 32'h2222;
    tick();
    idle();
    ifc.rsv_en = 1'b1; ifc.rsv_addr = 5'd0;
    ifc.rd_addr = {5'd1, 5'd0, 5'd2, 5'd1};
    tick();
    idle();
    #1;
    check("c_r0", {32'h0, ifc.rd_data[31:0]}, 64'h1111);
    check("c_r1", {32'h0, ifc.rd_data[63:32]}, 64'h2222);
    check("c_r2", {32'h0, ifc.rd_data[95:64]}, 64'h0);
    check("c_r3", {32'h0, ifc.rd_data[127:96]}, 64'h1111);
    check("c_busy", {60'h0, ifc.rd_busy}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
